fir_mc_par: RTL

FIR_MC_PAR -- requirements
Module: fir_mc_par

---
 rtl/fir_pkg.sv | 22 ++
 rtl/srl_ram.sv | 28 ++
 rtl/fir_mc_par.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, FSM encoding and accumulator sizing for the multichannel FIR.
package fir_pkg;

  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned CW_DEF  = 18;
  localparam int unsigned AW_DEF  = 7;
  localparam int unsigned NCH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Product width plus one bit per possible tap doubling: cannot wrap.
  function automatic int unsigned acc_w(int unsigned dw, int unsigned cw, int unsigned aw);
    return dw + cw + aw;
  endfunction

  localparam int unsigned ACC_W_DEF = acc_w(DW_DEF, CW_DEF, AW_DEF);

endpackage

// File: rtl/srl_ram.sv
// Shift-register memory: ce pushes d into address 0, older entries move up; async addressed read.
module srl_ram #(
  parameter int unsigned W  = 18,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          ce_i,
  input  logic [W-1:0]  d_i,
  input  logic [AW-1:0] addr_i,
  output logic [W-1:0]  q_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ce_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_c = mem_q[addr_i];

endmodule

// File: rtl/fir_mc_par.sv
// Multichannel FIR with shared coefficients: one tap per cycle across all channels,
// then round-half-up, gain shift and saturation into registered outputs.
module fir_mc_par
  import fir_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned NCH = NCH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     cin,
  input  logic [NCH*DW-1:0] din,
  input  logic              write,
  input  logic              load,
  input  logic              start,
  input  logic [AW-1:0]     ntaps,
  input  logic [AW-1:0]     cbase,
  input  logic [1:0]        gain,
  output logic [NCH*DW-1:0] dout,
  output logic              vld,
  output logic              busy,
  output logic [NCH-1:0]    ovf,
  output logic              err
);

  localparam int unsigned ACCW = acc_w(DW, CW, AW);
  localparam int unsigned PW   = DW + CW;
  localparam int unsigned RW   = ACCW + 4;
  localparam logic signed [RW-1:0] RND_HALF = RW'(longint'(1) << (CW - 2));
  localparam logic signed [RW-1:0] SAT_MAX  = RW'((longint'(1) << (DW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN  = ~SAT_MAX;

  state_e                 state_q, state_d;
  logic [AW-1:0]          tap_q, tap_d;
  logic [AW-1:0]          ntaps_q, ntaps_d;
  logic [AW-1:0]          cbase_q, cbase_d;
  logic [1:0]             gain_q, gain_d;
  logic signed [ACCW-1:0] acc_q [NCH];
  logic signed [ACCW-1:0] acc_d [NCH];
  logic [NCH*DW-1:0]      dout_q, dout_d;
  logic [NCH-1:0]         ovf_q, ovf_d;
  logic                   vld_q, vld_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic                   idle_c;
  logic [CW-1:0]          coef_c;
  logic [AW-1:0]          caddr_c;
  logic [DW-1:0]          samp_c [NCH];
  logic signed [PW-1:0]   prod_c [NCH];
  logic [NCH*DW-1:0]      res_c;
  logic [NCH-1:0]         sat_c;

  // Storage only changes while idle so a running pass sees stable operands.
  assign idle_c  = (state_q == ST_IDLE);
  assign caddr_c = cbase_q + tap_q;

  srl_ram #(.W(CW), .AW(AW)) u_coef (
    .clk    (clk),
    .ce_i   (load & idle_c),
    .d_i    (cin),
    .addr_i (caddr_c),
    .q_c    (coef_c)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [RW-1:0] acc_x, shl, rnd;
    logic                 pos_sat, neg_sat;

    srl_ram #(.W(DW), .AW(AW)) u_data (
      .clk    (clk),
      .ce_i   (write & idle_c),
      .d_i    (din[c*DW +: DW]),
      .addr_i (tap_q),
      .q_c    (samp_c[c])
    );

    assign prod_c[c] = PW'($signed(samp_c[c])) * PW'($signed(coef_c));

    // A zero-tap pass never touches the accumulator, so mask its stale contents.
    assign acc_x   = (ntaps_q == '0) ? RW'(0) : RW'(acc_q[c]);
    assign shl     = acc_x <<< gain_q;
    assign rnd     = (shl + RND_HALF) >>> (CW - 1);
    assign pos_sat = (rnd > SAT_MAX);
    assign neg_sat = (rnd < SAT_MIN);
    assign res_c[c*DW +: DW] = pos_sat ? DW'(SAT_MAX) : (neg_sat ? DW'(SAT_MIN) : DW'(rnd));
    assign sat_c[c] = pos_sat | neg_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tap_q   <= '0;
      ntaps_q <= '0;
      cbase_q <= '0;
      gain_q  <= '0;
      dout_q  <= '0;
      ovf_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      ntaps_q <= ntaps_d;
      cbase_q <= cbase_d;
      gain_q  <= gain_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    ntaps_d = ntaps_q;
    cbase_d = cbase_q;
    gain_d  = gain_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q | ((write | load | start) & ~idle_c);
    for (int c = 0; c < NCH; c++) acc_d[c] = acc_q[c];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ntaps_d = ntaps;
          cbase_d = cbase;
          gain_d  = gain;
          tap_d   = '0;
          busy_d  = 1'b1;
          state_d = (ntaps == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        for (int c = 0; c < NCH; c++) begin
          if (tap_q == '0) acc_d[c] = ACCW'(prod_c[c]);
          else             acc_d[c] = acc_q[c] + ACCW'(prod_c[c]);
        end
        tap_d = tap_q + AW'(1);
        if (tap_q == ntaps_q - AW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        dout_d  = res_c;
        ovf_d   = sat_c;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign vld  = vld_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule
